// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Frame constants cover both the 8N1 build and the UART_TX_PARITY_EN (8E1) build.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DATA_BITS      = 8;
  localparam int FRAME_BITS_8N1 = 10;
  localparam int FRAME_BITS_8E1 = 11;

  // Even parity: the bit that makes the total count of ones in byte+parity even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Holding clear keeps the count at zero so the next bit period starts aligned.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// Double-buffered UART transmitter: holding register feeding an 8N1 shifter.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ldtxdata,
  input  logic [7:0] txdata,
  output logic       txempty,
  output logic       txidle,
  output logic       overrun,
  output logic       tx
);

  tx_state_t            state;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] shift;
  logic                 hold_full;
  logic [2:0]           bit_idx;
  logic                 bit_end;
  logic                 stop_done;
  logic                 xfer;
  logic                 hold_full_nxt;
  logic                 idle_nxt;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .bit_end(bit_end)
  );

  // A held byte moves to the shifter whenever the line is free: at once from
  // IDLE, or on the last stop-bit cycle so frames run back to back.
  assign stop_done     = (state == STOP) && bit_end;
  assign xfer          = hold_full && ((state == IDLE) || stop_done);
  assign hold_full_nxt = ldtxdata || (hold_full && !xfer);
  assign idle_nxt      = !hold_full && ((state == IDLE) || stop_done);

  // NOTE: non-blocking assignments throughout, so every branch sees pre-edge
  // values -- shift <= hold picks up the old byte even when a new one lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shift     <= '0;
      bit_idx   <= '0;
      overrun   <= 1'b0;
      tx        <= 1'b1;
      txempty   <= 1'b1;
      txidle    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      if (ldtxdata) begin
        if (!hold_full || xfer) begin
          hold      <= txdata;
          hold_full <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (xfer) begin
        hold_full <= 1'b0;
      end

      txempty <= !hold_full_nxt;
      txidle  <= !hold_full_nxt && idle_nxt;

      if (xfer) begin
        shift <= hold;
        state <= START;
        tx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_bit <= even_parity(hold);
`endif
      end else begin
        case (state)
          IDLE: tx <= 1'b1;
          START: begin
            if (bit_end) begin
              state <= DATA;
              tx    <= shift[0];
            end
          end
          DATA: begin
            if (bit_end) begin
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                state <= PARITY;
                tx    <= parity_bit;
`else
                state <= STOP;
                tx    <= 1'b1;
`endif
              end else begin
                shift <= shift >> 1;
                tx    <= shift[1];
              end
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            if (bit_end) begin
              state <= STOP;
              tx    <= 1'b1;
            end
          end
`endif
          STOP: begin
            if (bit_end) begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
